logic_unit_arbiter: RTL and testbench

- Shares one 64-bit bitwise logic unit (AND/OR/XOR/NOR) between NUM_REQ requesters, such as integer issue slots and the branch/CSR path.
- Uses round-robin arbitration with per-requester valid/ready request handshakes.
- Has a single registered result stage with valid/ready backpressure toward writeback.
- Sits between the issue stage and the ALU writeback mux.

---
 rtl/logic_unit_pkg.sv | 15 +
 rtl/logic_unit_arbiter_rr_arbiter.sv | 45 ++++
 rtl/logic_unit_arbiter.sv | 137 +++++++++++++
 tb/tb_logic_unit_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared opcode constants and result-stage FSM encoding for the shared logic unit.
// Used by logic_unit_arbiter (optional statistics: LOGIC_ARB_STATS_EN).
package logic_unit_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/logic_unit_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the pointer, wrapping
// modulo NUM_REQ. Combinational; reusable by other shared ALU resources.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx
);

    localparam int SW = ID_W + 1;

    logic          w_found;
    logic [SW-1:0] w_sum;
    logic [ID_W-1:0] w_cand;

    // search upward from the pointer; the first hit wins
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + SW'(k);
            if (w_sum >= SW'(NUM_REQ)) begin
                w_sum = w_sum - SW'(NUM_REQ);
            end else begin
                w_sum = w_sum;
            end
            w_cand = w_sum[ID_W-1:0];
            if (i_en && !w_found && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                w_found         = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one bitwise logic unit between NUM_REQ requesters with a single registered result stage.
// Define LOGIC_ARB_STATS_EN to add per-requester grant counters and a stall counter.
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*2-1:0]     req_op,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_data,
    output logic [ID_W-1:0]          resp_id
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]    grant_count,
    output logic [31:0]              stall_count
`endif
);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic [ID_W-1:0]  r_ptr;
    logic             r_resp_valid;
    logic [WIDTH-1:0] r_resp_data;
    logic [ID_W-1:0]  r_resp_id;

    logic               w_can_accept;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_fire;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [1:0]         w_op;
    logic [WIDTH-1:0]   w_result;

    // the result slot frees up this cycle if it is empty or being drained
    assign w_can_accept = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && resp_ready);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_en    (w_can_accept && !reset),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign req_ready = w_grant;
    assign w_fire    = |w_grant;
    assign w_a       = req_a[int'(w_idx)*WIDTH +: WIDTH];
    assign w_b       = req_b[int'(w_idx)*WIDTH +: WIDTH];
    assign w_op      = req_op[int'(w_idx)*2 +: 2];

    // bitwise result of the granted requester
    always_comb begin
        w_result = '0;
        case (w_op)
            OP_AND:  w_result = w_a & w_b;
            OP_OR:   w_result = w_a | w_b;
            OP_XOR:  w_result = w_a ^ w_b;
            OP_NOR:  w_result = ~(w_a | w_b);
            default: w_result = '0;
        endcase
    end

    // next state: a grant always lands in HOLD, even while draining
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fire) w_next_state = ST_HOLD;
                else        w_next_state = ST_IDLE;
            end
            ST_HOLD: begin
                if (w_fire)          w_next_state = ST_HOLD;
                else if (resp_ready) w_next_state = ST_IDLE;
                else                 w_next_state = ST_HOLD;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // state, round-robin pointer and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_id    <= '0;
        end else begin
            r_state      <= w_next_state;
            r_resp_valid <= (w_next_state == ST_HOLD);
            if (w_fire) begin
                r_resp_data <= w_result;
                r_resp_id   <= w_idx;
                r_ptr       <= (w_idx == ID_W'(NUM_REQ-1)) ? '0 : w_idx + ID_W'(1);
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_id    = r_resp_id;

`ifdef LOGIC_ARB_STATS_EN
    logic [NUM_REQ*32-1:0] r_grant_count;
    logic [31:0]           r_stall_count;

    // free-running counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_count <= '0;
            r_stall_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i]) r_grant_count[i*32 +: 32] <= r_grant_count[i*32 +: 32] + 32'd1;
            end
            if ((r_state == ST_HOLD) && !resp_ready) r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign grant_count = r_grant_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed and randomized bench for logic_unit_arbiter against a behavioural model.
// Built with LOGIC_ARB_STATS_EN it also checks the statistics counters.
module tb_logic_unit_arbiter;

    localparam int N = 4;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*2-1:0] req_op;
    logic           resp_valid;
    logic           resp_ready;
    logic [W-1:0]   resp_data;
    logic [1:0]     resp_id;
`ifdef LOGIC_ARB_STATS_EN
    logic [N*32-1:0] grant_count;
    logic [31:0]     stall_count;
`endif

    logic_unit_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
`ifdef LOGIC_ARB_STATS_EN
        ,
        .grant_count (grant_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // behavioural model: pointer, occupancy flag and held result
    int           m_ptr;
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_id;
    int           last_g;

    function automatic logic [W-1:0] op_fn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    function automatic int model_grant();
        int j;
        if (reset) return -1;
        if (m_valid && !resp_ready) return -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock: check req_ready before the edge, advance model, check outputs after it
    task automatic cycle();
        int           g;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] exp_data;
        #3;
        g = model_grant();
        exp_rdy  = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        exp_data = '0;
        if (g >= 0) exp_data = op_fn(req_op[g*2 +: 2], req_a[g*W +: W], req_b[g*W +: W]);
        chk("req_ready", W'(req_ready), W'(exp_rdy));
        last_g = g;
        @(posedge clk);
        #1;
        if (reset) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_id    = 0;
            m_ptr   = 0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = exp_data;
            m_id    = g;
            m_ptr   = (g + 1) % N;
        end else if (m_valid && resp_ready) begin
            m_valid = 1'b0;
        end
        chk("resp_valid", W'(resp_valid), W'(m_valid));
        chk("resp_data", resp_data, m_data);
        chk("resp_id", W'(resp_id), W'(m_id));
    endtask

    logic [W-1:0] saved_data;
    logic [1:0]   saved_id;
    int           stalls;

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = 1'b1;
        m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = 0; last_g = -1;
        stalls = 0;

        // reset state
        cycle();
        cycle();
        reset = 1'b0;

        // single OR request from requester 1
        req_valid = 4'b0010;
        req_a[1*W +: W] = 64'hF0F0_0000_0000_00FF;
        req_b[1*W +: W] = 64'h0F0F_0000_0000_0F00;
        req_op[1*2 +: 2] = 2'b01;
        cycle();
        chk("single_grant", W'(last_g), W'(1));
        chk("single_data", resp_data, 64'hFFFF_0000_0000_0FFF);
        req_valid = '0;
        cycle();

        // restart pointer at 0, then all four valid continuously
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = {$urandom(), $urandom()};
            req_b[i*W +: W] = {$urandom(), $urandom()};
            req_op[i*2 +: 2] = 2'(i);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_id", W'(resp_id), W'(k % N));
        end
`ifdef LOGIC_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("grant_count", W'(grant_count[i*32 +: 32]), W'(2));
`endif

        // backpressure for 3 cycles with everyone still requesting
        saved_data = resp_data;
        saved_id   = resp_id;
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            stalls++;
            chk("bp_ready", W'(req_ready), W'(0));
            chk("bp_data", resp_data, saved_data);
            chk("bp_id", W'(resp_id), W'(saved_id));
        end
        resp_ready = 1'b1;
        cycle();
        chk("bp_release_grant", W'(last_g), W'((saved_id + 1) % N));
`ifdef LOGIC_ARB_STATS_EN
        chk("stall_count", W'(stall_count), W'(stalls));
`endif

        // opcode sweep on requester 0
        req_valid = 4'b0001;
        req_a[0 +: W] = {32{2'b10}};
        req_b[0 +: W] = '1;
        req_op[0 +: 2] = 2'b00; cycle(); chk("op_and", resp_data, {32{2'b10}});
        req_op[0 +: 2] = 2'b10; cycle(); chk("op_xor", resp_data, {32{2'b01}});
        req_op[0 +: 2] = 2'b11; cycle(); chk("op_nor", resp_data, 64'h0);
        req_op[0 +: 2] = 2'b01; cycle(); chk("op_or", resp_data, '1);

        // reset while holding a result
        req_valid  = 4'b0100;
        resp_ready = 1'b0;
        cycle();
        req_valid = '0;
        reset     = 1'b1;
        cycle();
        chk("rst_hold_valid", W'(resp_valid), W'(0));
        reset      = 1'b0;
        resp_ready = 1'b1;
        req_valid  = 4'b1111;
        cycle();
        chk("rst_ptr_grant", W'(last_g), W'(0));

        // randomized traffic; a requester holds its request until granted
        req_valid = '0;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    req_valid[i]     = 1'b1;
                    req_a[i*W +: W]  = {$urandom(), $urandom()};
                    req_b[i*W +: W]  = {$urandom(), $urandom()};
                    req_op[i*2 +: 2] = 2'($urandom_range(0, 3));
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (last_g >= 0) req_valid[last_g] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
